ps2_multi_debounce: RTL and testbench

Parametrised multi-channel input debouncer: the PS/2 clock and data lines, buttons and switches on the Nexys board all pass through one instance before reaching any decoder. Each channel is synchronised to `clk` and filtered by a programmable stability window, which can be stretched by a shared sample prescaler. The block produces a clean level per channel plus one-cycle rise and fall strobes, so PS/2 and keypad decoders consume edges directly instead of building their own edge detectors.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/debounce_channel.sv | 70 +++++++
 rtl/ps2_multi_debounce.sv | 52 +++++
 tb/tb_ps2_multi_debounce.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 / board-input debounce path: channel indices,
// default stability window and the filter counter width helper.
package ps2_pkg;

  localparam int PS2_CLK_CH       = 0;
  localparam int PS2_DATA_CH      = 1;
  localparam int PS2_STABLE_COUNT = 20;

  // Counter must hold 0..n inclusive so the saturated value n is representable.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce slice: 2-flop synchroniser, tick-gated stability filter, edge strobes.
// Latency STABLE_COUNT+3 clocks at one tick per clock; free-running, no backpressure.
module debounce_channel
  import ps2_pkg::*;
#(
  parameter int   STABLE_COUNT = PS2_STABLE_COUNT,
  parameter logic RESET_BIT    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic          s1_q, s2_q;
  logic          cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          rise_q, fall_q;

  // Saturated counter holds everything until s2 disagrees with the candidate.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (tick) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        cnt_d  = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = CNT_SAT;
        dout_d = cand_q;
      end else if (cnt_q != CNT_SAT) begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= RESET_BIT;
      s2_q   <= RESET_BIT;
      cand_q <= RESET_BIT;
      cnt_q  <= CNT_SAT;
      dout_q <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= ~dout_q & dout_d;
      fall_q <= dout_q & ~dout_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_multi_debounce.sv
// Multi-channel debouncer: shared sample prescaler feeding independent channel slices.
// Latency 2 + up to PRESCALE*(STABLE_COUNT+1) clocks; always valid, no backpressure.
module ps2_multi_debounce
  import ps2_pkg::*;
#(
  parameter int                  CHANNELS     = 2,
  parameter int                  STABLE_COUNT = PS2_STABLE_COUNT,
  parameter int                  PRESCALE     = 1,
  parameter logic [CHANNELS-1:0] RESET_VALUE  = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST  = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick;

  // With PRESCALE=1 the counter stays at 0 and every cycle is a tick.
  assign tick   = (pcnt_q == PCNT_LAST);
  assign pcnt_d = tick ? '0 : pcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_COUNT(STABLE_COUNT),
      .RESET_BIT   (RESET_VALUE[g])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .din  (din[g]),
      .dout (dout[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

endmodule

// File: tb/tb_ps2_multi_debounce.sv
// Directed bench: cycle table on a STABLE_COUNT=4 instance, then hand sequences
// for reset mid-count and the PRESCALE=3 / STABLE_COUNT=2 worst-case latency.
module tb_ps2_multi_debounce;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] din_a, din_b;
  logic [1:0] dout_a, rise_a, fall_a;
  logic [1:0] dout_b, rise_b, fall_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_multi_debounce #(
    .CHANNELS(2), .STABLE_COUNT(4), .PRESCALE(1), .RESET_VALUE(2'b11)
  ) dut_a (
    .clk(clk), .reset(rst_a), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a)
  );

  ps2_multi_debounce #(
    .CHANNELS(2), .STABLE_COUNT(2), .PRESCALE(3), .RESET_VALUE(2'b11)
  ) dut_b (
    .clk(clk), .reset(rst_b), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b)
  );

  typedef struct {
    logic       rst;
    logic [1:0] din;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic rst, input logic [1:0] din,
                     input logic [1:0] dout, input logic [1:0] rise, input logic [1:0] fall);
    vec_t v;
    v.rst = rst; v.din = din; v.dout = dout; v.rise = rise; v.fall = fall;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step(input logic ra, input logic [1:0] da, input logic rb, input logic [1:0] db);
    rst_a = ra; din_a = da; rst_b = rb; din_b = db;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; din_a = 2'b00; rst_b = 1'b1; din_b = 2'b11;

    // Vector k drives inputs before edge k; outputs are checked just after it.
    add(3, 1, 2'b00, 2'b11, 2'b00, 2'b00);  // reset with din low
    add(6, 0, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b11);  // edge 7 after deassert
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    add(6, 0, 2'b11, 2'b00, 2'b00, 2'b00);  // both back high
    add(1, 0, 2'b11, 2'b11, 2'b11, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00);
    add(6, 0, 2'b10, 2'b11, 2'b00, 2'b00);  // single-channel step on ch0
    add(1, 0, 2'b10, 2'b10, 2'b00, 2'b01);
    add(1, 0, 2'b10, 2'b10, 2'b00, 2'b00);
    add(6, 0, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00);
    add(4, 0, 2'b10, 2'b11, 2'b00, 2'b00);  // 4-clock glitch: rejected
    add(6, 0, 2'b11, 2'b11, 2'b00, 2'b00);
    add(5, 0, 2'b10, 2'b11, 2'b00, 2'b00);  // 5-clock glitch: passes
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 0, 2'b11, 2'b10, 2'b00, 2'b01);
    add(4, 0, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b01, 2'b00);
    add(1, 0, 2'b11, 2'b11, 2'b00, 2'b00);
    add(6, 0, 2'b00, 2'b11, 2'b00, 2'b00);  // simultaneous fall
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b11);
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].din, 1'b1, 2'b11);
      chk($sformatf("vec%0d dout", k), dout_a, vecs[k].dout);
      chk($sformatf("vec%0d rise", k), rise_a, vecs[k].rise);
      chk($sformatf("vec%0d fall", k), fall_a, vecs[k].fall);
    end

    // Reset mid-count: ch0 filter at count 2 when reset hits.
    step(1'b1, 2'b11, 1'b1, 2'b11);
    chk("midrst pre dout", dout_a, 2'b11);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b11, 1'b1, 2'b11);
    chk("midrst idle dout", dout_a, 2'b11);
    for (int k = 0; k < 5; k++) step(1'b0, 2'b10, 1'b1, 2'b11);
    chk("midrst counting dout", dout_a, 2'b11);
    step(1'b1, 2'b10, 1'b1, 2'b11);
    chk("midrst at reset dout", dout_a, 2'b11);
    chk("midrst at reset fall", fall_a, 2'b00);
    chk("midrst at reset rise", rise_a, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 2'b10, 1'b1, 2'b11);
      chk($sformatf("midrst e%0d dout", k), dout_a, 2'b11);
      chk($sformatf("midrst e%0d fall", k), fall_a, 2'b00);
    end
    step(1'b0, 2'b10, 1'b1, 2'b11);
    chk("midrst e7 dout", dout_a, 2'b10);
    chk("midrst e7 fall", fall_a, 2'b01);
    step(1'b0, 2'b10, 1'b1, 2'b11);
    chk("midrst e8 fall", fall_a, 2'b00);

    // Prescaler: ticks at the 3rd, 6th, 9th... edge after release. Step lands
    // in s2 on the 6th edge, just after a tick, giving the 11-clock worst case.
    chk("pre reset dout", dout_b, 2'b11);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b10, 1'b0, 2'b11);
    chk("pre idle dout", dout_b, 2'b11);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 2'b10, 1'b0, 2'b10);
      chk($sformatf("pre e%0d dout", k), dout_b, 2'b11);
      chk($sformatf("pre e%0d fall", k), fall_b, 2'b00);
    end
    step(1'b0, 2'b10, 1'b0, 2'b10);
    chk("pre e11 dout", dout_b, 2'b10);
    chk("pre e11 fall", fall_b, 2'b01);
    chk("pre e11 rise", rise_b, 2'b00);
    step(1'b0, 2'b10, 1'b0, 2'b10);
    chk("pre e12 dout", dout_b, 2'b10);
    chk("pre e12 fall", fall_b, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
